// File: rtl/bus_pkg.sv
// Shared types and widths for the shared-bus SRAM slave.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/bus_sram_slave_if.sv
// Controller-to-slave broadcast bus; wp exists only when BUS_SRAM_WRITE_PROTECT_EN is defined.
interface bus_sram_slave_if;
    import bus_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rreq;
    logic              wreq;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              ack;
`ifdef BUS_SRAM_WRITE_PROTECT_EN
    logic              wp;
`endif

    modport master (
        output addr, wdata, rreq, wreq,
`ifdef BUS_SRAM_WRITE_PROTECT_EN
        output wp,
`endif
        input  rdata, busy, ack
    );

    modport slave (
        input  addr, wdata, rreq, wreq,
`ifdef BUS_SRAM_WRITE_PROTECT_EN
        input  wp,
`endif
        output rdata, busy, ack
    );

endinterface

// File: rtl/sram_1rw.sv
// Synchronous single-port RAM, one-cycle read; dout only changes on a read.
module sram_1rw #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] index,
    input  logic [DATA_W-1:0]    din,
    output logic [DATA_W-1:0]    dout
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[index] <= din;
            else    dout_q     <= mem[index];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/bus_sram_slave.sv
// Word SRAM target on the shared bus with fixed window and programmable wait states.
// Optional write protect input enabled by BUS_SRAM_WRITE_PROTECT_EN.
//
// state   | meaning
// IDLE    | no access; a hit latches the request
// WAIT    | counting wait states on the latched request
// DONE    | one cycle with busy low; access completes
module bus_sram_slave
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    bus_sram_slave_if.slave bus
);

    localparam int         TAG_LSB = ADDR_BITS + 2;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    op_t                   op_q, op_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  req, in_win, aligned, wp_block, hit;
    logic [ADDR_BITS-1:0]  live_idx;
    op_t                   live_op;
    logic                  ram_en, ram_we;
    logic [ADDR_BITS-1:0]  ram_idx;
    logic [DATA_W-1:0]     ram_din, ram_dout;

    assign req      = bus.rreq | bus.wreq;
    assign in_win   = (bus.addr[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
    assign aligned  = (bus.addr[1:0] == 2'b00);
`ifdef BUS_SRAM_WRITE_PROTECT_EN
    assign wp_block = bus.wreq & bus.wp;
`else
    assign wp_block = 1'b0;
`endif
    assign hit      = req & in_win & aligned & ~wp_block;
    assign live_idx = bus.addr[TAG_LSB-1:2];
    assign live_op  = bus.wreq ? OP_WRITE : OP_READ;

    assign bus.ack   = hit;
    assign bus.busy  = hit & (state_q != ST_DONE);
    assign bus.rdata = rd_valid_q ? ram_dout : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        rd_valid_d = rd_valid_q;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_idx    = idx_q;
        ram_din    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    idx_d   = live_idx;
                    wdata_d = bus.wdata;
                    op_d    = live_op;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        // zero wait states: the access is issued on this very edge
                        state_d = ST_DONE;
                        ram_en  = 1'b1;
                        ram_we  = (live_op == OP_WRITE);
                        ram_idx = live_idx;
                        ram_din = bus.wdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_DONE;
                        ram_en  = 1'b1;
                        ram_we  = (op_q == OP_WRITE);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (ram_en && !ram_we) rd_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_q       <= OP_READ;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    sram_1rw #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .index (ram_idx),
        .din   (ram_din),
        .dout  (ram_dout)
    );

endmodule

// File: tb/tb_bus_sram_slave.sv
// Bench for bus_sram_slave: two instances (1 and 3 wait states) checked every cycle
// against a transaction-level model, plus directed scenarios.
module tb_bus_sram_slave;

    localparam longint BASE = 64'h8000;
    localparam longint WIN  = 4096;
    localparam int     NPRE = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic        t_rreq = 1'b0;
    logic        t_wreq = 1'b0;
    logic        t_wp = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bus_sram_slave_if b1();
    bus_sram_slave_if b3();

    assign b1.addr = t_addr;  assign b1.wdata = t_wdata;
    assign b1.rreq = t_rreq;  assign b1.wreq  = t_wreq;
    assign b3.addr = t_addr;  assign b3.wdata = t_wdata;
    assign b3.rreq = t_rreq;  assign b3.wreq  = t_wreq;
`ifdef BUS_SRAM_WRITE_PROTECT_EN
    assign b1.wp = t_wp;
    assign b3.wp = t_wp;
`endif

    bus_sram_slave #(.BASE_ADDR(32'h8000), .ADDR_BITS(10), .WAIT_CYCLES(1))
        dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    bus_sram_slave #(.BASE_ADDR(32'h8000), .ADDR_BITS(10), .WAIT_CYCLES(3))
        dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

    // reference model: per instance, an access in flight completes after a fixed number of held request cycles
    bit          m_act  [2];
    bit          m_done [2];
    int          m_left [2];
    int          m_idx  [2];
    logic [31:0] m_wd   [2];
    bit          m_wr   [2];
    logic [31:0] m_rd   [2];
    logic [31:0] m_mem  [2][1024];
    logic [31:0] pre    [NPRE];

    function automatic int wcyc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit mhit();
        longint a;
        bit     blocked;
        a = longint'(t_addr);
`ifdef BUS_SRAM_WRITE_PROTECT_EN
        blocked = t_wp && t_wreq;
`else
        blocked = 1'b0;
`endif
        return (t_rreq || t_wreq) && a >= BASE && a < BASE + WIN && (a % 4) == 0 && !blocked;
    endfunction

    function automatic int live_idx();
        return int'((longint'(t_addr) - BASE) / 4);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_act[k]  <= 1'b0;
                m_done[k] <= 1'b0;
                m_rd[k]   <= '0;
            end else if (m_done[k]) begin
                m_done[k] <= 1'b0;
            end else if (m_act[k]) begin
                if (!(t_rreq || t_wreq)) begin
                    m_act[k] <= 1'b0;
                end else if (m_left[k] == 1) begin
                    m_act[k]  <= 1'b0;
                    m_done[k] <= 1'b1;
                    if (m_wr[k]) m_mem[k][m_idx[k]] <= m_wd[k];
                    else         m_rd[k] <= m_mem[k][m_idx[k]];
                end else begin
                    m_left[k] <= m_left[k] - 1;
                end
            end else if (mhit()) begin
                m_idx[k]  <= live_idx();
                m_wd[k]   <= t_wdata;
                m_wr[k]   <= t_wreq;
                m_act[k]  <= 1'b1;
                m_left[k] <= wcyc(k);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_check();
        bit h;
        h = mhit();
        check_val("ack_w1",   32'(b1.ack),  32'(h));
        check_val("busy_w1",  32'(b1.busy), 32'(h && !m_done[0]));
        check_val("rdata_w1", b1.rdata,     m_rd[0]);
        check_val("ack_w3",   32'(b3.ack),  32'(h));
        check_val("busy_w3",  32'(b3.busy), 32'(h && !m_done[1]));
        check_val("rdata_w3", b3.rdata,     m_rd[1]);
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d, input bit r, input bit w);
        @(negedge clk);
        t_addr = a; t_wdata = d; t_rreq = r; t_wreq = w;
        #2;
        cyc++;
        model_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        t_rreq = 1'b0; t_wreq = 1'b0; reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // hold a request on dut1 until it reports busy low; n = cycles including the completion cycle
    task automatic hold1(input logic [31:0] a, input logic [31:0] d, input bit r, input bit w,
                         input string tag, output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step(a, d, r, w);
            n++;
            if (b1.busy === 1'b0) break;
        end
        check_val({tag, "_tmo"}, 32'(b1.busy), 32'h0);
    endtask

    initial begin
        int          n;
        int          done_cyc [3];
        logic [31:0] ca, cd;
        bit          cr, cw;

        for (int i = 0; i < NPRE; i++) pre[i] = $urandom;
        pre[1] = 32'h2333;
        pre[4] = 32'h55;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(1);
        check_val("rst_rdata", b1.rdata, 32'h0);
        check_val("rst_busy",  32'(b1.busy), 32'h0);
        check_val("rst_ack",   32'(b1.ack),  32'h0);

        // preload enough cycles for both instances to commit
        for (int i = 0; i < NPRE; i++) begin
            for (int j = 0; j < 5; j++) step(32'(BASE + 4 * i), pre[i], 1'b0, 1'b1);
            idle(1);
        end

        do_reset();
        idle(1);
        check_val("rst2_rdata", b1.rdata, 32'h0);

        step(32'h8004, 32'h0, 1'b1, 1'b0);
        check_val("rd_ack0",  32'(b1.ack),  32'h1);
        check_val("rd_busy0", 32'(b1.busy), 32'h1);
        step(32'h8004, 32'h0, 1'b1, 1'b0);
        check_val("rd_busy1", 32'(b1.busy), 32'h1);
        step(32'h8004, 32'h0, 1'b1, 1'b0);
        check_val("rd_busy2", 32'(b1.busy), 32'h0);
        check_val("rd_data",  b1.rdata,     32'h2333);
        idle(4);

        hold1(32'h8100, 32'h23, 1'b0, 1'b1, "wr", n);
        check_val("wr_lat", 32'(n), 32'd3);
        idle(4);
        hold1(32'h8100, 32'h0, 1'b1, 1'b0, "wrrd", n);
        check_val("wrrd_data", b1.rdata, 32'h23);
        idle(4);

        step(32'h2004, 32'h0, 1'b1, 1'b0);
        check_val("oow_ack",   32'(b1.ack),  32'h0);
        check_val("oow_busy",  32'(b1.busy), 32'h0);
        check_val("oow_rdata", b1.rdata,     32'h23);
        step(32'h8006, 32'h0, 1'b1, 1'b0);
        check_val("mis_ack",   32'(b1.ack),  32'h0);
        check_val("mis_busy",  32'(b1.busy), 32'h0);
        check_val("mis_rdata", b1.rdata,     32'h23);
        idle(4);

        for (int i = 0; i < 3; i++) begin
            hold1(32'h8004 + 32'(4 * i), 32'h0, 1'b1, 1'b0, "burst", n);
            done_cyc[i] = cyc;
            check_val("burst_data", b1.rdata, pre[1 + i]);
        end
        check_val("burst_gap01", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
        check_val("burst_gap12", 32'(done_cyc[2] - done_cyc[1]), 32'd3);
        idle(5);

        // dut3: write dropped during its wait states
        step(32'h8010, 32'h99, 1'b0, 1'b1);
        step(32'h8010, 32'h99, 1'b0, 1'b1);
        step(32'h0, 32'h0, 1'b0, 1'b0);
        check_val("abort_busy", 32'(b3.busy), 32'h0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step(32'h8010, 32'h0, 1'b1, 1'b0);
            n++;
            if (b3.busy === 1'b0) break;
        end
        check_val("abort_lat",  32'(n), 32'd5);
        check_val("abort_data", b3.rdata, 32'h55);
        idle(5);

`ifdef BUS_SRAM_WRITE_PROTECT_EN
        t_wp = 1'b1;
        step(32'h8000, 32'h77, 1'b0, 1'b1);
        check_val("wp_ack",  32'(b1.ack),  32'h0);
        check_val("wp_busy", 32'(b1.busy), 32'h0);
        step(32'h8000, 32'h77, 1'b0, 1'b1);
        step(32'h8000, 32'h77, 1'b0, 1'b1);
        idle(5);
        hold1(32'h8000, 32'h0, 1'b1, 1'b0, "wprd", n);
        check_val("wp_keep", b1.rdata, pre[0]);
        idle(5);
        t_wp = 1'b0;
        hold1(32'h8000, 32'h77, 1'b0, 1'b1, "wpok", n);
        idle(5);
        hold1(32'h8000, 32'h0, 1'b1, 1'b0, "wpok_rd", n);
        check_val("wp_retry", b1.rdata, 32'h77);
        idle(5);
`endif

        ca = 32'h8000; cd = 32'h0; cr = 1'b0; cw = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 9) < 3) begin
                int sel;
                sel = $urandom_range(0, 9);
                if (sel < 8)      ca = 32'(BASE + 4 * $urandom_range(0, NPRE - 1));
                else if (sel < 9) ca = 32'(BASE + 4 * $urandom_range(0, NPRE - 1) + $urandom_range(1, 3));
                else              ca = $urandom;
                cd = $urandom;
                cr = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0;
                cw = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0;
`ifdef BUS_SRAM_WRITE_PROTECT_EN
                t_wp = ($urandom_range(0, 4) == 0);
`endif
            end
            step(ca, cd, cr, cw);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
